// File: rtl/fixed_pkg.sv
// Shared types and helpers for the sequential sign-magnitude Booth multiplier.
package fixed_pkg;

    typedef enum logic [1:0] {IDLE, CALC, NORM, HOLD} mult_state_t;

    // Rounding mode: add the first discarded fraction bit back in.
    localparam logic ROUND_HALF_UP = 1'b1;

    // Widest magnitude the sign-magnitude helpers accept.
    localparam int SM_MAX_W = 64;

    // Round a width up to the next even number.
    function automatic int even_up(input int n);
        return (n % 2 == 0) ? n : n + 1;
    endfunction

    // True when a sign-magnitude magnitude field is zero.
    function automatic logic sm_is_zero(input logic [SM_MAX_W-1:0] mag);
        return (mag == '0);
    endfunction

    // Effective sign of a sign-magnitude value; a zero magnitude is never negative.
    function automatic logic sm_neg(input logic sign, input logic [SM_MAX_W-1:0] mag);
        return sign & ~sm_is_zero(mag);
    endfunction

endpackage

// File: rtl/booth_r4_recode.sv
// Booth digit recoder: 3-bit window in, {zero, neg, two} multiplicand select out.
module booth_r4_recode (
    input  logic [2:0] digit_i,
    output logic       zero_o,
    output logic       neg_o,
    output logic       two_o
);

    // Map the window {b[i+1], b[i], b[i-1]} to a digit in {-2,-1,0,+1,+2}.
    always_comb begin
        zero_o = (digit_i == 3'b000) || (digit_i == 3'b111);
        neg_o  = digit_i[2] & ~zero_o;
        two_o  = (digit_i == 3'b011) || (digit_i == 3'b100);
    end

endmodule

// File: rtl/fixed_seq_booth_mult.sv
// Sequential sign-magnitude Q-format multiplier with Booth recoding on the magnitudes,
// round-half-up and optional saturation, valid/ready on both sides.
module fixed_seq_booth_mult
    import fixed_pkg::*;
#(
    parameter int N        = 32,
    parameter int Q        = 16,
    parameter int RADIX4   = 1,
    parameter int SATURATE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] c,
    output logic         overflow
);

    localparam int M    = even_up(N);
    localparam int ITER = (RADIX4 != 0) ? M / 2 : M;
    localparam int CW   = $clog2(ITER + 1);
    localparam int AW   = 2 * M + 2;
    localparam int HW   = M + 2;

    mult_state_t   state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] acc_q, acc_d;
    logic          prev_q, prev_d;
    logic [M-1:0]  mcand_q, mcand_d;
    logic          sign_q, sign_d;
    logic [N-1:0]  c_q, c_d;
    logic          ovf_q, ovf_d;

    logic [2:0]        digit;
    logic              digZero, digNeg, digTwo;
    logic [HW-1:0]     baseMag, addend, hiSum;
    logic signed [AW-1:0] accSum, accStep;
    logic              prevStep;

    logic [AW:0]       pExt, pShift;
    logic [N-2:0]      field, magOut;
    logic [N-1:0]      rounded;
    logic              roundBit, highNz, ovfNorm, signOut;

    booth_r4_recode u_recode (
        .digit_i (digit),
        .zero_o  (digZero),
        .neg_o   (digNeg),
        .two_o   (digTwo)
    );

    // One Booth step: pick the multiplier window, add the selected multiple, shift right.
    always_comb begin
        digit    = (RADIX4 != 0) ? {acc_q[1], acc_q[0], prev_q} : {acc_q[0], acc_q[0], prev_q};
        baseMag  = digTwo ? {1'b0, mcand_q, 1'b0} : {2'b00, mcand_q};
        addend   = digZero ? '0 : (digNeg ? (~baseMag + HW'(1)) : baseMag);
        hiSum    = acc_q[AW-1:M] + addend;
        accSum   = {hiSum, acc_q[M-1:0]};
        accStep  = (RADIX4 != 0) ? (accSum >>> 2) : (accSum >>> 1);
        prevStep = (RADIX4 != 0) ? acc_q[1] : acc_q[0];
    end

    // Align the finished product to Q, round half-up, detect overflow, clamp or wrap.
    always_comb begin
        pExt     = {acc_q, 1'b0};
        pShift   = pExt >> Q;
        field    = pShift[N-1:1];
        roundBit = ROUND_HALF_UP & pShift[0];
        highNz   = |pShift[AW:N];
        rounded  = {1'b0, field} + {{(N-1){1'b0}}, roundBit};
        ovfNorm  = highNz | rounded[N-1];
        magOut   = rounded[N-2:0];
        if (ovfNorm && (SATURATE != 0)) begin
            magOut = '1;
        end
        signOut  = sm_neg(sign_q, SM_MAX_W'(magOut));
    end

    // Control FSM: accept in IDLE, iterate in CALC, normalise once, hold until consumed.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        acc_d     = acc_q;
        prev_d    = prev_q;
        mcand_d   = mcand_q;
        sign_d    = sign_q;
        c_d       = c_q;
        ovf_d     = ovf_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    mcand_d = M'(a[N-2:0]);
                    acc_d   = AW'(b[N-2:0]);
                    prev_d  = 1'b0;
                    sign_d  = a[N-1] ^ b[N-1];
                    count_d = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                acc_d   = accStep;
                prev_d  = prevStep;
                count_d = count_q + CW'(1);
                if (count_q == CW'(ITER - 1)) begin
                    state_d = NORM;
                end
            end
            NORM: begin
                c_d     = {signOut, magOut};
                ovf_d   = ovfNorm;
                state_d = HOLD;
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            acc_q   <= '0;
            prev_q  <= 1'b0;
            mcand_q <= '0;
            sign_q  <= 1'b0;
            c_q     <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            acc_q   <= acc_d;
            prev_q  <= prev_d;
            mcand_q <= mcand_d;
            sign_q  <= sign_d;
            c_q     <= c_d;
            ovf_q   <= ovf_d;
        end
    end

    assign c        = c_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_fixed_seq_booth_mult.sv
// Scoreboard bench for fixed_seq_booth_mult: four parameterisations run side by side.
module tb_fixed_seq_booth_mult;

    logic        clk = 1'b0;
    logic        rst;
    logic        inValid, outReady;
    logic [15:0] a16, b16;
    logic [31:0] a32, b32;
    logic [7:0]  a8, b8;

    logic        rdyA, vldA, ovfA, rdyB, vldB, ovfB;
    logic        rdyC, vldC, ovfC, rdyD, vldD, ovfD;
    logic [15:0] cA, cB;
    logic [31:0] cC;
    logic [7:0]  cD;

    logic [16:0] qA[$];
    logic [16:0] qB[$];
    logic [32:0] qC[$];
    logic [8:0]  qD[$];

    int checkCount = 0;
    int passCount  = 0;
    bit sawValid   = 1'b0;

    // Free-running clock.
    always #5 clk = ~clk;

    fixed_seq_booth_mult #(.N(16), .Q(8), .RADIX4(1), .SATURATE(1)) dutA (
        .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(rdyA), .a(a16), .b(b16),
        .out_valid(vldA), .out_ready(outReady), .c(cA), .overflow(ovfA));

    fixed_seq_booth_mult #(.N(16), .Q(8), .RADIX4(0), .SATURATE(0)) dutB (
        .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(rdyB), .a(a16), .b(b16),
        .out_valid(vldB), .out_ready(outReady), .c(cB), .overflow(ovfB));

    fixed_seq_booth_mult #(.N(32), .Q(4), .RADIX4(1), .SATURATE(0)) dutC (
        .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(rdyC), .a(a32), .b(b32),
        .out_valid(vldC), .out_ready(outReady), .c(cC), .overflow(ovfC));

    fixed_seq_booth_mult #(.N(8), .Q(6), .RADIX4(0), .SATURATE(1)) dutD (
        .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(rdyD), .a(a8), .b(b8),
        .out_valid(vldD), .out_ready(outReady), .c(cD), .overflow(ovfD));

    // Reference: exact unsigned product, shift, round half-up, overflow when it exceeds N-1 bits.
    function automatic logic [64:0] refMult(input int n, input int q, input bit sat,
                                            input logic [63:0] x, input logic [63:0] y);
        logic [63:0] mask, p, full, mag;
        logic        sgn, ovf, rnd;
        mask = (64'd1 << (n - 1)) - 64'd1;
        p    = (x & mask) * (y & mask);
        sgn  = x[n-1] ^ y[n-1];
        rnd  = (q > 0) ? p[q-1] : 1'b0;
        full = (p >> q) + {63'd0, rnd};
        ovf  = (full > mask);
        mag  = ovf ? (sat ? mask : (full & mask)) : full;
        sgn  = sgn && (mag != 64'd0);
        return {ovf, (64'(sgn) << (n - 1)) | mag};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Result monitors: pop the scoreboard whenever a result is consumed.
    always @(negedge clk) begin
        logic [64:0] e;
        if (!rst) begin
            if (vldA || vldB || vldC || vldD) sawValid = 1'b1;
            if (vldA && outReady) begin
                if (qA.size() == 0) checkOutput("A unexpected result", 64'(vldA), 64'd0);
                else begin e = 65'(qA.pop_front()); checkOutput("A {ovf,c}", 64'({ovfA, cA}), e[63:0]); end
            end
            if (vldB && outReady) begin
                if (qB.size() == 0) checkOutput("B unexpected result", 64'(vldB), 64'd0);
                else begin e = 65'(qB.pop_front()); checkOutput("B {ovf,c}", 64'({ovfB, cB}), e[63:0]); end
            end
            if (vldC && outReady) begin
                if (qC.size() == 0) checkOutput("C unexpected result", 64'(vldC), 64'd0);
                else begin e = 65'(qC.pop_front()); checkOutput("C {ovf,c}", 64'({ovfC, cC}), e[63:0]); end
            end
            if (vldD && outReady) begin
                if (qD.size() == 0) checkOutput("D unexpected result", 64'(vldD), 64'd0);
                else begin e = 65'(qD.pop_front()); checkOutput("D {ovf,c}", 64'({ovfD, cD}), e[63:0]); end
            end
        end
    end

    task automatic applyStimulus(input logic [15:0] x, input logic [15:0] y,
                                 input logic [16:0] expA, input logic [16:0] expB);
        int          guard = 0;
        logic [64:0] r;
        while (!(rdyA && rdyB && rdyC && rdyD) && guard < 200) begin
            @(posedge clk); #1; guard++;
        end
        if (guard >= 200) checkOutput("ready timeout", 64'({rdyA, rdyB, rdyC, rdyD}), 64'hF);
        a16 = x;
        b16 = y;
        a32 = $urandom;
        b32 = $urandom;
        a8  = 8'($urandom);
        b8  = 8'($urandom);
        qA.push_back(expA);
        qB.push_back(expB);
        r = refMult(32, 4, 1'b0, 64'(a32), 64'(b32));
        qC.push_back({r[64], r[31:0]});
        r = refMult(8, 6, 1'b1, 64'(a8), 64'(b8));
        qD.push_back({r[64], r[7:0]});
        inValid = 1'b1;
        @(posedge clk); #1;
        inValid = 1'b0;
        a16 = 16'($urandom);
        b16 = 16'($urandom);
        a32 = $urandom;
        b32 = $urandom;
        a8  = 8'($urandom);
        b8  = 8'($urandom);
    endtask

    task automatic waitDrain();
        int guard = 0;
        while ((qA.size() + qB.size() + qC.size() + qD.size()) != 0 && guard < 200) begin
            @(posedge clk); #1; guard++;
        end
        if (guard >= 200)
            checkOutput("drain timeout", 64'(qA.size() + qB.size() + qC.size() + qD.size()), 64'd0);
    endtask

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        logic [16:0] expA;
        logic [16:0] expB;
    } vec_t;

    vec_t directed[10] = '{
        '{16'h0180, 16'h0200, 17'h00300, 17'h00300},
        '{16'h8180, 16'h0200, 17'h08300, 17'h08300},
        '{16'h8180, 16'h8200, 17'h00300, 17'h00300},
        '{16'h0001, 16'h0080, 17'h00001, 17'h00001},
        '{16'h0001, 16'h0040, 17'h00000, 17'h00000},
        '{16'h8000, 16'h0100, 17'h00000, 17'h00000},
        '{16'h8001, 16'h0000, 17'h00000, 17'h00000},
        '{16'h7FFF, 16'h7FFF, 17'h17FFF, 17'h17F00},
        '{16'h1111, 16'h0780, 17'h17FFF, 17'h10000},
        '{16'h9111, 16'h0780, 17'h1FFFF, 17'h10000}
    };

    // Directed steps, back-pressure, mid-operation reset, then a random sweep.
    initial begin
        int          latA, latB, guard;
        logic [64:0] rA, rB;
        rst = 1'b1; inValid = 1'b0; outReady = 1'b1;
        a16 = '0; b16 = '0; a32 = '0; b32 = '0; a8 = '0; b8 = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        checkOutput("reset A {rdy,vld,ovf,c}", 64'({rdyA, vldA, ovfA, cA}), 64'({1'b1, 1'b0, 1'b0, 16'h0}));
        checkOutput("reset B {rdy,vld,ovf,c}", 64'({rdyB, vldB, ovfB, cB}), 64'({1'b1, 1'b0, 1'b0, 16'h0}));

        // First operation also measures accept-to-valid latency.
        applyStimulus(directed[0].x, directed[0].y, directed[0].expA, directed[0].expB);
        latA = 0; latB = 0;
        for (int e = 1; e <= 30; e++) begin
            @(posedge clk); #1;
            if (vldA && latA == 0) latA = e;
            if (vldB && latB == 0) latB = e;
        end
        checkOutput("latency A (radix-4)", 64'(latA), 64'd9);
        checkOutput("latency B (radix-2)", 64'(latB), 64'd17);
        waitDrain();

        for (int i = 1; i < 10; i++) begin
            applyStimulus(directed[i].x, directed[i].y, directed[i].expA, directed[i].expB);
            waitDrain();
        end

        // Back-pressure: result held, no new operand taken while in HOLD.
        $display("[TB] back-pressure phase");
        outReady = 1'b0;
        applyStimulus(16'h0180, 16'h0200, 17'h00300, 17'h00300);
        guard = 0;
        while (!vldA && guard < 40) begin @(posedge clk); #1; guard++; end
        if (guard >= 40) checkOutput("A valid timeout", 64'(vldA), 64'd1);
        inValid = 1'b1; a16 = 16'h0100; b16 = 16'h0100;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checkOutput("hold A {vld,rdy,ovf,c}", 64'({vldA, rdyA, ovfA, cA}), 64'({1'b1, 1'b0, 1'b0, 16'h0300}));
        end
        inValid = 1'b0;
        outReady = 1'b1;
        @(posedge clk); #1;
        checkOutput("release A {vld,rdy}", 64'({vldA, rdyA}), 64'({1'b0, 1'b1}));
        waitDrain();
        applyStimulus(16'h0100, 16'h0100, 17'h00100, 17'h00100);
        waitDrain();

        // Reset during CALC discards the operation.
        $display("[TB] mid-operation reset phase");
        applyStimulus(16'h0180, 16'h0200, 17'h00300, 17'h00300);
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        qA.delete(); qB.delete(); qC.delete(); qD.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("abort A {vld,rdy,ovf,c}", 64'({vldA, rdyA, ovfA, cA}), 64'({1'b0, 1'b1, 1'b0, 16'h0}));
        checkOutput("abort B {vld,rdy,ovf,c}", 64'({vldB, rdyB, ovfB, cB}), 64'({1'b0, 1'b1, 1'b0, 16'h0}));
        sawValid = 1'b0;
        repeat (30) begin @(posedge clk); #1; end
        checkOutput("no stale result after reset", 64'(sawValid), 64'd0);

        // Random sweep against the reference model.
        for (int i = 0; i < 24; i++) begin
            logic [15:0] x, y;
            x = 16'($urandom);
            y = 16'($urandom);
            if (i % 3 == 0) y = y & 16'h81FF;
            rA = refMult(16, 8, 1'b1, 64'(x), 64'(y));
            rB = refMult(16, 8, 1'b0, 64'(x), 64'(y));
            applyStimulus(x, y, {rA[64], rA[15:0]}, {rB[64], rB[15:0]});
            waitDrain();
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
